// File: rtl/uart_pkg.sv
// Shared UART types and constants for the RX buffer and, later, the TX path.
package uart_pkg;
  localparam int UART_DATA_W = 8;

  typedef enum logic {
    RXB_IDLE = 1'b0,
    RXB_ACK  = 1'b1
  } rx_buf_state_t;
endpackage

// File: rtl/uart_rx_buffer_if.sv
// Receiver-side and bus-side signals of the UART RX buffer.
interface uart_rx_buffer_if #(parameter int DEPTH = 16);
  import uart_pkg::*;
  localparam int AW = $clog2(DEPTH);

  logic                   rx_ready_i;
  logic [UART_DATA_W-1:0] rx_data_i;
  logic                   rx_clear_o;
  logic                   rd_valid_o;
  logic [UART_DATA_W-1:0] rd_data_o;
  logic                   rd_ready_i;
  logic [AW:0]            count_o;
  logic                   overrun_o;
  logic                   overrun_clr_i;

  modport slave (
    input  rx_ready_i, rx_data_i, rd_ready_i, overrun_clr_i,
    output rx_clear_o, rd_valid_o, rd_data_o, count_o, overrun_o
  );

  modport master (
    output rx_ready_i, rx_data_i, rd_ready_i, overrun_clr_i,
    input  rx_clear_o, rd_valid_o, rd_data_o, count_o, overrun_o
  );
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO; push/pop arrive already qualified against full/empty.
module uart_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  // Memory is not reset, so gate the head to keep the output X-free when empty.
  assign dout  = empty ? '0 : mem[rptr];
endmodule

// File: rtl/uart_rx_buffer.sv
// Captures receiver bytes with a one-cycle clear acknowledge and queues them for the bus side.
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_rx_buffer_if.slave bus
);
  rx_buf_state_t state;
  logic          rx_clear;
  logic          overrun;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;

  assign push_req = (state == RXB_IDLE) && bus.rx_ready_i;
  assign pop      = !empty && bus.rd_ready_i;
  // A full FIFO still accepts the byte when the head leaves on the same edge.
  assign push     = push_req && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RXB_IDLE;
      rx_clear <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      case (state)
        RXB_IDLE: begin
          if (bus.rx_ready_i) begin
            state    <= RXB_ACK;
            rx_clear <= 1'b1;
          end
        end
        RXB_ACK: begin
          state    <= RXB_IDLE;
          rx_clear <= 1'b0;
        end
        default: begin
          state    <= RXB_IDLE;
          rx_clear <= 1'b0;
        end
      endcase
      if (push_req && !push)      overrun <= 1'b1;
      else if (bus.overrun_clr_i) overrun <= 1'b0;
    end
  end

  uart_sync_fifo #(.WIDTH(UART_DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (bus.rx_data_i),
    .dout  (bus.rd_data_o),
    .count (bus.count_o),
    .full  (full),
    .empty (empty)
  );

  assign bus.rx_clear_o = rx_clear;
  assign bus.rd_valid_o = !empty;
  assign bus.overrun_o  = overrun;
endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed bench for uart_rx_buffer with a queue-based reference model checked every cycle.
module tb_uart_rx_buffer;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  uart_rx_buffer_if #(.DEPTH(DEPTH)) bus();

  uart_rx_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  logic [7:0] mq[$];
  bit         m_ovr = 1'b0;
  bit         m_clear = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a byte is taken whenever ready is seen outside a clear pulse.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ovr   = 1'b0;
      m_clear = 1'b0;
    end else begin
      automatic bit pop  = (mq.size() != 0) && bus.rd_ready_i;
      automatic bit cap  = bus.rx_ready_i && !m_clear;
      automatic bit room = (mq.size() < DEPTH) || pop;
      if (pop) void'(mq.pop_front());
      if (cap && room) mq.push_back(bus.rx_data_i);
      if (cap && !room) m_ovr = 1'b1;
      else if (bus.overrun_clr_i) m_ovr = 1'b0;
      m_clear = cap;
    end
  end

  always @(negedge clk) begin
    check("m_rd_valid", bus.rd_valid_o, (mq.size() != 0));
    check("m_rd_data",  bus.rd_data_o,  (mq.size() != 0) ? mq[0] : 8'h00);
    check("m_count",    bus.count_o,    mq.size());
    check("m_overrun",  bus.overrun_o,  m_ovr);
    check("m_rx_clear", bus.rx_clear_o, m_clear);
    if (bus.rx_clear_o === 1'b1) pulses++;
  end

  // Receiver behaviour: ready stays up until the clear pulse has been seen.
  task automatic send(input logic [7:0] b, input bit pop_too);
    bit seen = 1'b0;
    @(negedge clk);
    bus.rx_data_i  = b;
    bus.rx_ready_i = 1'b1;
    if (pop_too) bus.rd_ready_i = 1'b1;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge clk);
      bus.rd_ready_i = 1'b0;
      if (bus.rx_clear_o === 1'b1) seen = 1'b1;
    end
    if (!seen) check("send_timeout", 0, 1);
    @(posedge clk);
    #1 bus.rx_ready_i = 1'b0;
  endtask

  task automatic pop_chk(input logic [7:0] exp);
    @(negedge clk);
    check("pop_data", bus.rd_data_o, exp);
    bus.rd_ready_i = 1'b1;
    @(negedge clk);
    bus.rd_ready_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_count"},    bus.count_o,    0);
    check({tag, "_rd_valid"}, bus.rd_valid_o, 0);
    check({tag, "_rd_data"},  bus.rd_data_o,  0);
    check({tag, "_rx_clear"}, bus.rx_clear_o, 0);
    check({tag, "_overrun"},  bus.overrun_o,  0);
  endtask

  initial begin
    int p0;
    bus.rx_ready_i    = 1'b0;
    bus.rx_data_i     = 8'h00;
    bus.rd_ready_i    = 1'b0;
    bus.overrun_clr_i = 1'b0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // single byte
    p0 = pulses;
    send(8'hA5, 1'b0);
    @(negedge clk);
    check("t1_pulses", pulses - p0, 1);
    check("t1_valid", bus.rd_valid_o, 1);
    check("t1_data", bus.rd_data_o, 8'hA5);
    check("t1_count", bus.count_o, 1);
    pop_chk(8'hA5);
    @(negedge clk);
    check("t1_count_after_pop", bus.count_o, 0);

    // burst to full, drain in order, then refill across the pointer wrap
    for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
    @(negedge clk);
    check("t2_count_full", bus.count_o, 16);
    check("t2_overrun", bus.overrun_o, 0);
    for (int i = 0; i < 16; i++) pop_chk(8'(i));
    for (int i = 0; i < 16; i++) send(8'h20 + 8'(i), 1'b0);
    @(negedge clk);
    check("t2_count_refill", bus.count_o, 16);

    // overrun on a full FIFO
    p0 = pulses;
    send(8'h77, 1'b0);
    @(negedge clk);
    check("t3_pulses", pulses - p0, 1);
    check("t3_overrun", bus.overrun_o, 1);
    check("t3_count", bus.count_o, 16);
    check("t3_head", bus.rd_data_o, 8'h20);
    bus.overrun_clr_i = 1'b1;
    @(negedge clk);
    bus.overrun_clr_i = 1'b0;
    check("t3_overrun_clr", bus.overrun_o, 0);

    // full with simultaneous pop on the capture edge
    send(8'h77, 1'b1);
    @(negedge clk);
    check("t4_count", bus.count_o, 16);
    check("t4_overrun", bus.overrun_o, 0);
    for (int i = 1; i < 16; i++) pop_chk(8'h20 + 8'(i));
    pop_chk(8'h77);
    @(negedge clk);
    check("t4_empty", bus.count_o, 0);

    // one assertion of sticky ready gives one byte and one clear pulse
    p0 = pulses;
    send(8'h3C, 1'b0);
    repeat (5) @(negedge clk);
    check("t5_pulses", pulses - p0, 1);
    check("t5_count", bus.count_o, 1);

    // reset in the middle of an acknowledge
    send(8'h41, 1'b0);
    send(8'h42, 1'b0);
    send(8'h43, 1'b0);
    @(negedge clk);
    bus.rx_data_i  = 8'h55;
    bus.rx_ready_i = 1'b1;
    @(negedge clk);
    check("t6_count_pre", bus.count_o, 5);
    check("t6_clear_pre", bus.rx_clear_o, 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("t6_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_recap_count", bus.count_o, 1);
    check("t6_recap_data", bus.rd_data_o, 8'h55);
    check("t6_recap_clear", bus.rx_clear_o, 1);
    @(posedge clk);
    #1 bus.rx_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_count_post", bus.count_o, 1);
    pop_chk(8'h55);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
